// File: rtl/pulse_level_arbiter_pkg.sv
// Shared types and limits for the pulse-to-level round-robin arbiter.
package pulse_level_arbiter_pkg;

   localparam int unsigned MAX_N = 16;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

endpackage

// File: rtl/pulse_level_arbiter_if.sv
// Requester pulse inputs and arbitration level outputs, bundled for the arbiter port.
interface pulse_level_arbiter_if #(
   parameter int unsigned N = 4
);
   localparam int unsigned IDW = $clog2(N);

   logic [N-1:0]   start;
   logic [N-1:0]   stop;
   logic [N-1:0]   pend;
   logic [N-1:0]   gnt;
   logic           owner_valid;
   logic [IDW-1:0] owner_id;
   logic           timeout;

   modport master (
      output start, stop,
      input  pend, gnt, owner_valid, owner_id, timeout
   );

   modport slave (
      input  start, stop,
      output pend, gnt, owner_valid, owner_id, timeout
   );

endinterface

// File: rtl/pla_req_latch.sv
// One pending-request bit: start sets it, stop clears it, force_clr wins over both.
module pla_req_latch (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic stop,
   input  logic force_clr,
   output logic pend
);

   // A start on a held request is ignored, so start+stop together toggles the bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend <= 1'b0;
      end else if (force_clr) begin
         pend <= 1'b0;
      end else if (!pend && start) begin
         pend <= 1'b1;
      end else if (pend && stop) begin
         pend <= 1'b0;
      end
   end

endmodule

// File: rtl/pulse_level_arbiter.sv
// Round-robin arbiter turning per-requester start/stop pulses into a held one-hot grant.
// Define PULSE_LEVEL_ARBITER_TIMEOUT_EN to force release after MAX_HOLD grant cycles.
module pulse_level_arbiter #(
   parameter int unsigned N        = 4,
   parameter int unsigned MAX_HOLD = 16
) (
   input logic                  clk,
   input logic                  rst,
   pulse_level_arbiter_if.slave bus
);
   import pulse_level_arbiter_pkg::*;

   localparam int unsigned IDW = $clog2(N);

   if (N < 2 || N > MAX_N || MAX_HOLD < 2) begin : g_bad_cfg
      $error("pulse_level_arbiter: N must be 2..16 and MAX_HOLD >= 2");
   end

   state_t         state, state_nx;
   logic [N-1:0]   pend;
   logic [N-1:0]   gnt, gnt_nx;
   logic [N-1:0]   force_clr;
   logic           owner_valid, owner_valid_nx;
   logic [IDW-1:0] owner_id, owner_id_nx;
   logic [IDW-1:0] rr_ptr, rr_ptr_nx;
   logic [IDW-1:0] pick;
   logic           owner_stop;
   logic           expired;

`ifdef PULSE_LEVEL_ARBITER_TIMEOUT_EN
   localparam int unsigned HCW = $clog2(MAX_HOLD + 1);
   logic [HCW-1:0] hold_cnt, hold_cnt_nx;
   logic           timeout, timeout_nx;
   assign expired = (hold_cnt == HCW'(MAX_HOLD));
`else
   assign expired = 1'b0;
`endif

   for (genvar i = 0; i < N; i++) begin : g_req
      pla_req_latch u_latch (
         .clk       (clk),
         .rst       (rst),
         .start     (bus.start[i]),
         .stop      (bus.stop[i]),
         .force_clr (force_clr[i]),
         .pend      (pend[i])
      );
   end

   // First pending index after ptr, wrapping; the last owner is searched last.
   function automatic logic [IDW-1:0] rr_pick(input logic [N-1:0] req, input logic [IDW-1:0] ptr);
      int idx;
      rr_pick = ptr;
      for (int k = int'(N); k >= 1; k--) begin
         idx = (int'(ptr) + k) % int'(N);
         if (req[idx]) rr_pick = IDW'(idx);
      end
   endfunction

   assign owner_stop = bus.stop[owner_id];

   always_comb begin
      state_nx       = state;
      gnt_nx         = gnt;
      owner_valid_nx = owner_valid;
      owner_id_nx    = owner_id;
      rr_ptr_nx      = rr_ptr;
      force_clr      = '0;
      pick           = rr_pick(pend, rr_ptr);
`ifdef PULSE_LEVEL_ARBITER_TIMEOUT_EN
      hold_cnt_nx    = hold_cnt;
      timeout_nx     = 1'b0;
`endif
      unique case (state)
         IDLE: begin
            if (|pend) begin
               state_nx       = GRANT;
               gnt_nx         = '0;
               gnt_nx[pick]   = 1'b1;
               owner_valid_nx = 1'b1;
               owner_id_nx    = pick;
               rr_ptr_nx      = pick;
`ifdef PULSE_LEVEL_ARBITER_TIMEOUT_EN
               hold_cnt_nx    = HCW'(1);
`endif
            end
         end
         GRANT: begin
            if (owner_stop || expired) begin
               state_nx       = IDLE;
               gnt_nx         = '0;
               owner_valid_nx = 1'b0;
               owner_id_nx    = '0;
`ifdef PULSE_LEVEL_ARBITER_TIMEOUT_EN
               hold_cnt_nx    = '0;
               // A stop in the expiry cycle is a normal release, not a timeout.
               if (!owner_stop) begin
                  force_clr[owner_id] = 1'b1;
                  timeout_nx          = 1'b1;
               end
`endif
            end
`ifdef PULSE_LEVEL_ARBITER_TIMEOUT_EN
            else begin
               hold_cnt_nx = hold_cnt + HCW'(1);
            end
`endif
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         gnt         <= '0;
         owner_valid <= 1'b0;
         owner_id    <= '0;
         rr_ptr      <= IDW'(N - 1);
      end else begin
         state       <= state_nx;
         gnt         <= gnt_nx;
         owner_valid <= owner_valid_nx;
         owner_id    <= owner_id_nx;
         rr_ptr      <= rr_ptr_nx;
      end
   end

`ifdef PULSE_LEVEL_ARBITER_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_cnt <= '0;
         timeout  <= 1'b0;
      end else begin
         hold_cnt <= hold_cnt_nx;
         timeout  <= timeout_nx;
      end
   end

   assign bus.timeout = timeout;
`else
   assign bus.timeout = 1'b0;
`endif

   assign bus.pend        = pend;
   assign bus.gnt         = gnt;
   assign bus.owner_valid = owner_valid;
   assign bus.owner_id    = owner_id;

endmodule

// File: tb/tb_pulse_level_arbiter.sv
// Scoreboard bench for pulse_level_arbiter: directed pulses, expected output snapshots per cycle.
module tb_pulse_level_arbiter;

   localparam int unsigned N        = 4;
   localparam int unsigned MAX_HOLD = 16;
   localparam int unsigned IDW      = $clog2(N);
   localparam int unsigned OBW      = 2 * N + IDW + 2;

   typedef struct {
      int             cyc;
      logic [N-1:0]   pend;
      logic [N-1:0]   gnt;
      logic           ov;
      logic [IDW-1:0] id;
      logic           to;
      string          name;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   exp_t sb[$];

   pulse_level_arbiter_if #(.N(N)) bus ();

   pulse_level_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic void expect_at(input int c, input logic [N-1:0] p, input logic [N-1:0] g,
                                     input logic t, input string nm);
      exp_t e;
      e.cyc  = c;
      e.pend = p;
      e.gnt  = g;
      e.ov   = |g;
      e.id   = '0;
      e.to   = t;
      e.name = nm;
      for (int i = 0; i < int'(N); i++) if (g[i]) e.id = IDW'(i);
      sb.push_back(e);
   endfunction

   task automatic at_cycle(input int k);
      while (cyc < k) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse(input int k, input logic [N-1:0] s, input logic [N-1:0] p);
      at_cycle(k);
      bus.start = s;
      bus.stop  = p;
      @(posedge clk);
      #1;
      bus.start = '0;
      bus.stop  = '0;
   endtask

   // Monitor: compare on every scheduled snapshot, and flag any output change nobody expected.
   logic [OBW-1:0] obs, prev_obs, exp_obs;
   exp_t           e;
   always @(negedge clk) begin
      obs = {bus.pend, bus.gnt, bus.owner_valid, bus.owner_id, bus.timeout};
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
         e       = sb.pop_front();
         exp_obs = {e.pend, e.gnt, e.ov, e.id, e.to};
         vectors++;
         if (obs !== exp_obs) begin
            miscompares++;
            $display("FAIL %s @cycle %0d: got pend=%b gnt=%b ov=%b id=%0d to=%b, want pend=%b gnt=%b ov=%b id=%0d to=%b",
                     e.name, cyc, bus.pend, bus.gnt, bus.owner_valid, bus.owner_id, bus.timeout,
                     e.pend, e.gnt, e.ov, e.id, e.to);
         end
      end else if (cyc > 1 && obs !== prev_obs) begin
         vectors++;
         miscompares++;
         $display("FAIL unexpected_change @cycle %0d: got pend=%b gnt=%b ov=%b id=%0d to=%b, want unchanged %b",
                  cyc, bus.pend, bus.gnt, bus.owner_valid, bus.owner_id, bus.timeout, prev_obs);
      end
      prev_obs = obs;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start = '0;
      bus.stop  = '0;

      expect_at(1, 4'b0000, 4'b0000, 1'b0, "reset");
      at_cycle(2);
      rst = 1'b0;

      // Round robin from reset pointer N-1: order 0,1,3, then 0 again.
      expect_at(4,  4'b1011, 4'b0000, 1'b0, "rr_pend");
      expect_at(5,  4'b1011, 4'b0001, 1'b0, "rr_gnt0");
      expect_at(9,  4'b1010, 4'b0000, 1'b0, "rr_gap0");
      expect_at(10, 4'b1010, 4'b0010, 1'b0, "rr_gnt1");
      expect_at(14, 4'b1000, 4'b0000, 1'b0, "rr_gap1");
      expect_at(15, 4'b1000, 4'b1000, 1'b0, "rr_gnt3");
      expect_at(17, 4'b1001, 4'b1000, 1'b0, "rr_rereq0");
      expect_at(19, 4'b0001, 4'b0000, 1'b0, "rr_gap3");
      expect_at(20, 4'b0001, 4'b0001, 1'b0, "rr_gnt0_again");
      expect_at(24, 4'b0000, 4'b0000, 1'b0, "rr_done");
      pulse(3,  4'b1011, 4'b0000);
      pulse(8,  4'b0000, 4'b0001);
      pulse(13, 4'b0000, 4'b0010);
      pulse(16, 4'b0001, 4'b0000);
      pulse(18, 4'b0000, 4'b1000);
      pulse(23, 4'b0000, 4'b0001);

      // Single request; a start from the current owner changes nothing.
      expect_at(28, 4'b0100, 4'b0000, 1'b0, "single_pend");
      expect_at(29, 4'b0100, 4'b0100, 1'b0, "single_gnt");
      expect_at(32, 4'b0100, 4'b0100, 1'b0, "owner_start_ignored");
      expect_at(35, 4'b0000, 4'b0000, 1'b0, "single_release");
      pulse(27, 4'b0100, 4'b0000);
      pulse(31, 4'b0100, 4'b0000);
      pulse(34, 4'b0000, 4'b0100);

      // Withdraw by a non-owner; stop on an idle requester is harmless.
      expect_at(39, 4'b0011, 4'b0000, 1'b0, "wd_pend");
      expect_at(40, 4'b0011, 4'b0001, 1'b0, "wd_gnt0");
      expect_at(43, 4'b0001, 4'b0001, 1'b0, "wd_withdraw1");
      expect_at(46, 4'b0000, 4'b0000, 1'b0, "wd_release0");
      expect_at(48, 4'b0000, 4'b0000, 1'b0, "wd_no_grant1");
      pulse(38, 4'b0011, 4'b0000);
      pulse(42, 4'b0000, 4'b0110);
      pulse(45, 4'b0000, 4'b0001);

      // start+stop together toggles the pending bit.
      expect_at(51, 4'b1000, 4'b0000, 1'b0, "toggle_on");
      expect_at(52, 4'b1000, 4'b1000, 1'b0, "toggle_gnt3");
      expect_at(54, 4'b0000, 4'b0000, 1'b0, "toggle_off");
      pulse(50, 4'b1000, 4'b1000);
      pulse(53, 4'b1000, 4'b1000);

      // Asynchronous reset in the middle of a grant.
      expect_at(58, 4'b1011, 4'b0000, 1'b0, "rst_pend");
      expect_at(59, 4'b1011, 4'b0001, 1'b0, "rst_gnt0");
      expect_at(61, 4'b0000, 4'b0000, 1'b0, "rst_async_clear");
      expect_at(62, 4'b0000, 4'b0000, 1'b0, "rst_held");
      expect_at(66, 4'b0001, 4'b0000, 1'b0, "post_rst_pend");
      expect_at(67, 4'b0001, 4'b0001, 1'b0, "post_rst_gnt");
      expect_at(70, 4'b0000, 4'b0000, 1'b0, "post_rst_release");
      pulse(57, 4'b1011, 4'b0000);
      at_cycle(61);
      rst = 1'b1;
      at_cycle(63);
      rst = 1'b0;
      pulse(65, 4'b0001, 4'b0000);
      pulse(69, 4'b0000, 4'b0001);

      // Owner never stops.
      expect_at(73, 4'b0110, 4'b0000, 1'b0, "hold_pend");
      expect_at(74, 4'b0110, 4'b0010, 1'b0, "hold_gnt1");
      expect_at(89, 4'b0110, 4'b0010, 1'b0, "hold_cycle16");
`ifdef PULSE_LEVEL_ARBITER_TIMEOUT_EN
      expect_at(90, 4'b0100, 4'b0000, 1'b1, "timeout_pulse");
      expect_at(91, 4'b0100, 4'b0100, 1'b0, "timeout_next_gnt2");
      expect_at(94, 4'b0000, 4'b0000, 1'b0, "timeout_done");
      pulse(72, 4'b0110, 4'b0000);
      pulse(93, 4'b0000, 4'b0100);
`else
      expect_at(90,  4'b0110, 4'b0010, 1'b0, "no_timeout_17");
      expect_at(110, 4'b0110, 4'b0010, 1'b0, "no_timeout_37");
      expect_at(113, 4'b0100, 4'b0000, 1'b0, "hold_release1");
      expect_at(114, 4'b0100, 4'b0100, 1'b0, "hold_gnt2");
      expect_at(117, 4'b0000, 4'b0000, 1'b0, "hold_done");
      pulse(72,  4'b0110, 4'b0000);
      pulse(112, 4'b0000, 4'b0010);
      pulse(116, 4'b0000, 4'b0100);
`endif

      at_cycle(125);
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: got %0d unchecked entries (next %s @cycle %0d), want 0",
                  sb.size(), sb[0].name, sb[0].cyc);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
